wb_arbiter_2to1: RTL and testbench
==================================

Name: wb_arbiter_2to1

Overview:
Two-master to one-slave pipelined Wishbone B4 arbiter that shares the single BRAM memory slave port between an instruction-fetch master (m0) and a load/store master (m1). Grant is held for the whole bus cycle (CYC) of the granted master. Ties are broken round-robin. Outstanding requests are tracked so that only the owning master receives ACKs.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-unacknowledged requests per grant (1..15)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_we_i  in  1  master 0 write enable
m0_sel_i  in  4  master 0 byte select
m0_stb_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle
m0_ack_o  out  1  master 0 acknowledge
m0_stall_o  out  1  master 0 stall
m1_*  same set as m0_*, for master 1
s_adr_o  out  32  slave address
s_dat_o  out  32  slave write data
s_dat_i  in  32  slave read data
s_we_o  out  1  slave write enable
s_sel_o  out  4  slave byte select
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_ack_i  in  1  slave acknowledge
s_stall_i  in  1  slave stall

Behaviour:
- State register: IDLE, GRANT0, GRANT1.
- last_q: 1 bit, the last granted master.
- cnt_q: outstanding counter, width $clog2(MAX_OUTSTANDING+1).
- Reset (async, rst_ni=0): state IDLE, last_q=1 (m0 wins the first tie), cnt_q=0.
- Outputs are combinational from state. Reset and IDLE values:
  - s_cyc_o=0, s_stb_o=0, s_we_o=0.
  - m0_ack_o=0, m1_ack_o=0.
  - m0_stall_o=1, m1_stall_o=1.
  - s_adr_o/s_dat_o/s_sel_o=0.
- IDLE transitions:
  - Only m0_cyc_i -> GRANT0.
  - Only m1_cyc_i -> GRANT1.
  - Both -> the master != last_q.
  - Neither -> stay.
  - Grant is registered: the earliest a request can be accepted is 1 cycle after CYC rises.
- GRANTx outputs:
  - s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i.
  - s_adr_o/s_dat_o/s_we_o/s_sel_o mux from mx.
  - mx_ack_o=s_ack_i.
  - Non-granted master: ack=0, stall=1.
- GRANTx stall: mx_stall_o = s_stall_i OR (cnt_q==MAX_OUTSTANDING). When cnt_q==MAX_OUTSTANDING, s_stb_o is forced to 0.
- Request acceptance: acc = s_stb_o AND NOT s_stall_i.
- Counter update: cnt_q += acc, cnt_q -= s_ack_i. A simultaneous acc and ack leaves the count unchanged. An ack with cnt_q==0 is ignored and does not underflow.
- GRANTx exit: when mx_cyc_i=0, next state IDLE, last_q<=x, cnt_q<=0. The exit cycle drives s_cyc_o=0 (an abort per Wishbone).
- Late ACKs: any ACK arriving in IDLE is discarded and never forwarded.
- Minimum gap between grants: 1 IDLE cycle. Dropping CYC and regranting always passes through IDLE.
- Read data: m0_dat_o = m1_dat_o = s_dat_i, qualified only by the respective ack.
- Slave timing: with the BRAM slave (ack 1 cycle after stb, no stall), a single master sustains one request per cycle when MAX_OUTSTANDING>=2.

Test Plan:
- Single read, m0: after reset, m0 cyc/stb, adr=0x10, we=0.
  - Cycle 0: m0_stall_o=1.
  - Cycle 1: s_stb_o=1, s_adr_o=0x10.
  - Cycle 2: m0_ack_o=1 with s_dat_i=0xDEADBEEF on m0_dat_o.
  - m1_ack_o stays 0 throughout.
- Tie after reset: m0 and m1 assert cyc together.
  - GRANT0 first; m1_stall_o=1 throughout.
  - m0 drops cyc -> 1 IDLE cycle -> GRANT1, s_adr_o = m1_adr_i.
- Round-robin: after GRANT1 ends, both request again -> GRANT0. Repeat -> GRANT1; grants alternate 4 times.
- Outstanding limit, MAX_OUTSTANDING=2: m1 issues 4 writes (adr 0x0,0x4,0x8,0xC), slave acks held off 3 cycles.
  - After 2 accepts: m1_stall_o=1, s_stb_o=0.
  - Each ack frees one slot.
  - Exactly 4 s_ack_i pass to m1_ack_o; cnt_q returns to 0.
- Abort with pending ack: m0 read accepted, then m0 drops cyc before the ack.
  - State -> IDLE, cnt_q=0.
  - The following s_ack_i pulse gives m0_ack_o=0 and m1_ack_o=0.
- Async reset mid-burst: rst_ni falls between clock edges during GRANT1 with cnt_q=1.
  - Outputs immediately go to reset values (s_cyc_o=0, both stalls=1).
  - After release, a tie grants m0.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// wb_arbiter_2to1
// Shares one pipelined Wishbone B4 slave (BRAM) between an instruction-fetch
// master (m0) and a load/store master (m1). A grant lasts for the whole CYC
// of the winning master, simultaneous requests alternate round-robin, and
// an outstanding-request counter throttles the owner so that at most
// MAX_OUTSTANDING accepted strobes are waiting for their ACK.
// Dropping CYC aborts the cycle: the counter is cleared and any ACK that
// arrives afterwards (while IDLE) is swallowed, never reaching a master.
module wb_arbiter_2to1 #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_stall_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_stall_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    input  logic        s_stall_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full;
    logic             acc;
    logic             dec;
    logic [CNT_W-1:0] cnt_upd;

    // Owner may not issue another strobe while the pipeline holds the
    // maximum number of unacknowledged requests.
    assign full = (cnt_q == CNT_MAX);

    // A request is taken by the slave when strobed and not stalled.
    assign acc = s_stb_o & ~s_stall_i;

    // ACKs with nothing outstanding are ignored so the counter never wraps.
    assign dec = s_ack_i & (cnt_q != '0);

    // Read data is broadcast; each master qualifies it with its own ACK.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Outstanding count after this cycle's accept and ack; both together cancel.
    always_comb begin
        cnt_upd = cnt_q;
        unique case ({acc, dec})
            2'b10:   cnt_upd = cnt_q + CNT_W'(1);
            2'b01:   cnt_upd = cnt_q - CNT_W'(1);
            default: cnt_upd = cnt_q;
        endcase
    end

    // State, round-robin pointer and outstanding counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate from IDLE, hold grant until the owner drops CYC.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc_i && m1_cyc_i) begin
                    // last_q names the previous winner, so the other one goes now
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (m0_cyc_i) begin
                    state_d = GRANT0;
                end else if (m1_cyc_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_upd;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_upd;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus steering: connect the owner to the slave, park everyone else.
    always_comb begin
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_we_o     = 1'b0;
        s_sel_o    = '0;
        s_stb_o    = 1'b0;
        s_cyc_o    = 1'b0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        unique case (state_q)
            GRANT0: begin
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                s_we_o     = m0_we_i;
                s_sel_o    = m0_sel_i;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_cyc_i & m0_stb_i & ~full;
                m0_ack_o   = s_ack_i;
                m0_stall_o = s_stall_i | full;
            end
            GRANT1: begin
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                s_we_o     = m1_we_i;
                s_sel_o    = m1_sel_i;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_cyc_i & m1_stb_i & ~full;
                m1_ack_o   = s_ack_i;
                m1_stall_o = s_stall_i | full;
            end
            default: begin
                // IDLE: late ACKs are dropped here, both masters held off
                s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1 (MAX_OUTSTANDING = 2): a per-cycle vector table
// followed by hand-written abort, outstanding-limit and async-reset sequences.
module tb_wb_arbiter_2to1;

    localparam logic [31:0] M0_ADR = 32'h0000_0010;
    localparam logic [31:0] M1_ADR = 32'h0000_0020;
    localparam logic [31:0] M0_DAT = 32'h1111_0000;
    localparam logic [31:0] M1_DAT = 32'h2222_0000;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;
    localparam logic [31:0] RDATA  = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_stall;
    logic [3:0]  m0_sel;
    logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_stall;
    logic [3:0]  m1_sel;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_we, s_stb, s_cyc, s_ack, s_stall;
    logic [3:0]  s_sel;

    int checks   = 0;
    int failures = 0;

    wb_arbiter_2to1 #(.MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
        .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_ack_o(m0_ack), .m0_stall_o(m0_stall),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
        .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_ack_o(m1_ack), .m1_stall_o(m1_stall),
        .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
        .s_we_o(s_we), .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
        .s_ack_i(s_ack), .s_stall_i(s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in : {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
    // ex : {s_cyc, s_stb, src[1:0] (0 none,1 m0,2 m1), m0_ack, m1_ack, m0_stall, m1_stall}
    typedef struct {
        logic [5:0] in;
        logic [7:0] ex;
    } vec_t;

    vec_t tbl [33];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   issued, acks1, acks0, out, seen_full, n;
        int   due[$];
        logic acc, got_ack;
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        logic        ewe;

        tbl[0]  = '{6'b110000, 8'b0_0_00_0_0_1_1};
        tbl[1]  = '{6'b110000, 8'b1_1_01_0_0_0_1};
        tbl[2]  = '{6'b100010, 8'b1_0_01_1_0_0_1};
        tbl[3]  = '{6'b001100, 8'b0_0_01_0_0_0_1};
        tbl[4]  = '{6'b001100, 8'b0_0_00_0_0_1_1};
        tbl[5]  = '{6'b001100, 8'b1_1_10_0_0_1_0};
        tbl[6]  = '{6'b001010, 8'b1_0_10_0_1_1_0};
        tbl[7]  = '{6'b000000, 8'b0_0_10_0_0_1_0};
        tbl[8]  = '{6'b111100, 8'b0_0_00_0_0_1_1};
        tbl[9]  = '{6'b111100, 8'b1_1_01_0_0_0_1};
        tbl[10] = '{6'b101110, 8'b1_0_01_1_0_0_1};
        tbl[11] = '{6'b001100, 8'b0_0_01_0_0_0_1};
        tbl[12] = '{6'b001100, 8'b0_0_00_0_0_1_1};
        tbl[13] = '{6'b111100, 8'b1_1_10_0_0_1_0};
        tbl[14] = '{6'b111010, 8'b1_0_10_0_1_1_0};
        tbl[15] = '{6'b110000, 8'b0_0_10_0_0_1_0};
        tbl[16] = '{6'b111100, 8'b0_0_00_0_0_1_1};
        tbl[17] = '{6'b111101, 8'b1_1_01_0_0_1_1};
        tbl[18] = '{6'b001100, 8'b0_0_01_0_0_0_1};
        tbl[19] = '{6'b111100, 8'b0_0_00_0_0_1_1};
        tbl[20] = '{6'b111100, 8'b1_1_10_0_0_1_0};
        tbl[21] = '{6'b111100, 8'b1_1_10_0_0_1_0};
        tbl[22] = '{6'b001100, 8'b1_0_10_0_0_1_1};
        tbl[23] = '{6'b001110, 8'b1_0_10_0_1_1_1};
        tbl[24] = '{6'b001110, 8'b1_1_10_0_1_1_0};
        tbl[25] = '{6'b001010, 8'b1_0_10_0_1_1_0};
        tbl[26] = '{6'b001010, 8'b1_0_10_0_1_1_0};
        tbl[27] = '{6'b001100, 8'b1_1_10_0_0_1_0};
        tbl[28] = '{6'b001100, 8'b1_1_10_0_0_1_0};
        tbl[29] = '{6'b001100, 8'b1_0_10_0_0_1_1};
        tbl[30] = '{6'b000000, 8'b0_0_10_0_0_1_1};
        tbl[31] = '{6'b000010, 8'b0_0_00_0_0_1_1};
        tbl[32] = '{6'b000000, 8'b0_0_00_0_0_1_1};

        m0_adr = M0_ADR; m0_dat_w = M0_DAT; m0_we = 1'b0; m0_sel = M0_SEL;
        m1_adr = M1_ADR; m1_dat_w = M1_DAT; m1_we = 1'b1; m1_sel = M1_SEL;
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        s_ack = 0; s_stall = 0; s_dat_r = RDATA;
        rst_n = 1'b0;

        // ---------------- reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_we", 32'(s_we), 0);
        chk("rst_s_adr", s_adr, 0);
        chk("rst_s_dat", s_dat_w, 0);
        chk("rst_s_sel", 32'(s_sel), 0);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_m0_stall", 32'(m0_stall), 1);
        chk("rst_m1_stall", 32'(m1_stall), 1);
        rst_n = 1'b1;

        // ---------------- table: single read, tie, round robin, stall, limit
        for (int i = 0; i < 33; i++) begin
            step();
            {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall} = tbl[i].in;
            @(negedge clk);
            case (tbl[i].ex[5:4])
                2'd1:    begin eadr = M0_ADR; edat = M0_DAT; esel = M0_SEL; ewe = 1'b0; end
                2'd2:    begin eadr = M1_ADR; edat = M1_DAT; esel = M1_SEL; ewe = 1'b1; end
                default: begin eadr = 0; edat = 0; esel = 0; ewe = 1'b0; end
            endcase
            chk($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(tbl[i].ex[7]));
            chk($sformatf("v%0d_s_stb", i), 32'(s_stb), 32'(tbl[i].ex[6]));
            chk($sformatf("v%0d_s_adr", i), s_adr, eadr);
            chk($sformatf("v%0d_s_dat", i), s_dat_w, edat);
            chk($sformatf("v%0d_s_sel", i), 32'(s_sel), 32'(esel));
            chk($sformatf("v%0d_s_we", i), 32'(s_we), 32'(ewe));
            chk($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(tbl[i].ex[3]));
            chk($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(tbl[i].ex[2]));
            chk($sformatf("v%0d_m0_stall", i), 32'(m0_stall), 32'(tbl[i].ex[1]));
            chk($sformatf("v%0d_m1_stall", i), 32'(m1_stall), 32'(tbl[i].ex[0]));
            if (tbl[i].ex[3]) chk($sformatf("v%0d_m0_dat", i), m0_dat_r, RDATA);
            if (tbl[i].ex[2]) chk($sformatf("v%0d_m1_dat", i), m1_dat_r, RDATA);
        end

        // ---------------- abort with pending ack (IDLE, last=1)
        step(); m0_cyc = 1; m0_stb = 1; s_ack = 0; s_stall = 0;
        step();
        @(negedge clk);
        chk("abort_accept_stb", 32'(s_stb), 1);
        step(); m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        chk("abort_exit_cyc", 32'(s_cyc), 0);
        step(); s_ack = 1;
        @(negedge clk);
        chk("abort_late_m0_ack", 32'(m0_ack), 0);
        chk("abort_late_m1_ack", 32'(m1_ack), 0);
        chk("abort_idle_cyc", 32'(s_cyc), 0);
        step(); s_ack = 0; m0_cyc = 1; m0_stb = 1;
        step();
        @(negedge clk);
        chk("abort_cnt0_req1_stall", 32'(m0_stall), 0);
        chk("abort_cnt0_req1_stb", 32'(s_stb), 1);
        step();
        @(negedge clk);
        chk("abort_cnt0_req2_stall", 32'(m0_stall), 0);
        chk("abort_cnt0_req2_stb", 32'(s_stb), 1);
        step(); m0_cyc = 0; m0_stb = 0;
        step();

        // ---------------- outstanding limit: m1 writes 0x0..0xC, acks 3 cycles late
        issued = 0; acks0 = 0; acks1 = 0; out = 0; seen_full = 0;
        m1_cyc = 1;
        for (n = 0; n < 20; n++) begin
            step();
            if (due.size() > 0 && due[0] == n) begin
                s_ack = 1;
                void'(due.pop_front());
            end else begin
                s_ack = 0;
            end
            m1_stb = (issued < 4);
            m1_adr = 32'(issued * 4);
            @(negedge clk);
            if (out == 2) begin
                seen_full++;
                chk($sformatf("lim_n%0d_m1_stall", n), 32'(m1_stall), 1);
                chk($sformatf("lim_n%0d_s_stb", n), 32'(s_stb), 0);
            end
            acc = s_stb & ~s_stall;
            if (acc) begin
                chk($sformatf("lim_adr%0d", issued), s_adr, 32'(issued * 4));
                issued++;
                due.push_back(n + 3);
            end
            got_ack = s_ack;
            if (m1_ack) acks1++;
            if (m0_ack) acks0++;
            out = out + (acc ? 1 : 0) - ((got_ack && out > 0) ? 1 : 0);
        end
        chk("lim_issued", 32'(issued), 4);
        chk("lim_m1_acks", 32'(acks1), 4);
        chk("lim_m0_acks", 32'(acks0), 0);
        chk("lim_full_seen", 32'(seen_full > 0), 1);
        chk("lim_out_zero", 32'(out), 0);
        step(); s_ack = 0; m1_stb = 0; m1_cyc = 0;
        step();
        @(negedge clk);
        chk("lim_idle_cyc", 32'(s_cyc), 0);

        // ---------------- async reset during GRANT1 with one outstanding
        m1_adr = M1_ADR;
        step(); m1_cyc = 1; m1_stb = 1;
        step();
        @(negedge clk);
        chk("ar_accept_stb", 32'(s_stb), 1);
        step(); m1_stb = 0;
        #2 rst_n = 1'b0; s_ack = 1;
        #1;
        chk("ar_s_cyc", 32'(s_cyc), 0);
        chk("ar_s_stb", 32'(s_stb), 0);
        chk("ar_m0_stall", 32'(m0_stall), 1);
        chk("ar_m1_stall", 32'(m1_stall), 1);
        chk("ar_m1_ack", 32'(m1_ack), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; s_ack = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(posedge clk);
        @(negedge clk);
        chk("ar_tie_s_cyc", 32'(s_cyc), 1);
        chk("ar_tie_s_adr", s_adr, M0_ADR);
        chk("ar_tie_m0_stall", 32'(m0_stall), 0);
        chk("ar_tie_m1_stall", 32'(m1_stall), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
